reg_pipe_nb: RTL and testbench

//  Parametrised elastic pipeline register: STAGES back-to-back skid-buffer stages of N-bit data.

---
 rtl/reg_pkg.sv | 26 ++
 rtl/reg_skid_nb.sv | 107 ++++++++++
 rtl/reg_pipe_nb.sv | 109 ++++++++++
 tb/tb_reg_pipe_nb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// ---------------------------------------------------------------------------
// reg_pkg
//   Shared definitions for the elastic pipeline register (reg_pipe_nb) and
//   its single skid stage (reg_skid_nb).
//   - stage_state_e : per-stage occupancy state (EMPTY / BUSY / FULL)
//   - occ_width()   : width of the optional occupancy counter, sized so it
//                     can represent 0 .. 2*stages inclusive
// ---------------------------------------------------------------------------
package reg_pkg;

  // EMPTY : neither main nor skid holds a word
  // BUSY  : main holds a word, skid is free (stage still ready)
  // FULL  : main and skid both hold a word (stage not ready)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Each stage can hold two words, and the count must reach its maximum
  // value 2*stages, hence the +1.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/reg_skid_nb.sv
// ---------------------------------------------------------------------------
// reg_skid_nb
//   One elastic skid-buffer stage. A main register feeds the output and a
//   skid register catches the word that arrives in the cycle the downstream
//   stalls. in_ready is decoded purely from the state register, so there is
//   no combinational path from out_ready back to in_ready.
//
// Parameters
//   N          data width
// Ports
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset (clears state and data)
//   flush      synchronous flush: drops all held words, keeps data contents
//   in_valid   upstream word valid
//   in_data    upstream word
//   in_ready   stage can accept (skid register empty)
//   out_valid  main register holds a word
//   out_data   main register contents
//   out_ready  downstream accepts
// ---------------------------------------------------------------------------
module reg_skid_nb
  import reg_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready
);

  stage_state_e state_q, state_d;
  logic [N-1:0] mainData_q, mainData_d;
  logic [N-1:0] skidData_q, skidData_d;
  logic         push, pop;

  // The valid bits of main and skid are implied by the state: main is valid
  // in BUSY and FULL, skid only in FULL. Ready is therefore just "not FULL".
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = mainData_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next-state and data-load decisions. Flush wins over any handshake and
  // leaves the data registers untouched, only the occupancy is cleared.
  // When the downstream stalls while a new word arrives, the new word parks
  // in skid; on the next pop the skid word is promoted into main so order
  // is preserved.
  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d    = BUSY;
            mainData_d = in_data;
          end
        end
        BUSY: begin
          if (push && pop) begin
            mainData_d = in_data;
          end else if (push) begin
            state_d    = FULL;
            skidData_d = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d    = BUSY;
            mainData_d = skidData_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and data registers; reset clears both so the output reads zero
  // immediately when clr_n drops, without waiting for a clock edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= EMPTY;
      mainData_q <= '0;
      skidData_q <= '0;
    end else begin
      state_q    <= state_d;
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
    end
  end

endmodule

// File: rtl/reg_pipe_nb.sv
// ---------------------------------------------------------------------------
// reg_pipe_nb
//   Parametrised elastic pipeline register: STAGES reg_skid_nb stages chained
//   valid/data forward and ready backward. Full throughput, strict FIFO
//   ordering, capacity 2*STAGES words, latency STAGES cycles when unstalled.
//
// Parameters
//   N          data width (default 8)
//   STAGES     number of skid stages, >= 1 (default 2)
// Ports
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   flush      synchronous flush of all held words
//   in_valid   upstream word valid
//   in_data    upstream word
//   in_ready   first stage can accept (registered)
//   out_valid  last stage holds a word
//   out_data   word from the last stage
//   occ        words held (only with REG_PIPE_OCC_EN defined)
//   out_ready  downstream accepts
//
// Configuration
//   REG_PIPE_OCC_EN  when defined, adds the occ output and its counter
// ---------------------------------------------------------------------------
module reg_pipe_nb
  import reg_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic                             clk,
  input  logic                             clr_n,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [N-1:0]                     in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [N-1:0]                     out_data,
`ifdef REG_PIPE_OCC_EN
  output logic [occ_width(STAGES)-1:0]     occ,
`endif
  input  logic                             out_ready
);

  // Index i of each chain is the interface between stage i-1 and stage i;
  // index 0 is the pipe input and index STAGES is the pipe output.
  logic [STAGES:0]        validChain;
  logic [STAGES:0]        readyChain;
  logic [STAGES:0][N-1:0] dataChain;

  assign validChain[0]      = in_valid;
  assign dataChain[0]       = in_data;
  assign in_ready           = readyChain[0];
  assign out_valid          = validChain[STAGES];
  assign out_data           = dataChain[STAGES];
  assign readyChain[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    reg_skid_nb #(
      .N(N)
    ) u_stage (
      .clk       (clk),
      .clr_n     (clr_n),
      .flush     (flush),
      .in_valid  (validChain[i]),
      .in_data   (dataChain[i]),
      .in_ready  (readyChain[i]),
      .out_valid (validChain[i+1]),
      .out_data  (dataChain[i+1]),
      .out_ready (readyChain[i+1])
    );
  end

`ifdef REG_PIPE_OCC_EN
  localparam int OCC_W = occ_width(STAGES);

  logic             occPush, occPop;
  logic [OCC_W-1:0] occCount_q, occCount_d;

  assign occPush = in_valid & in_ready;
  assign occPop  = out_valid & out_ready;

  // Occupancy tracks only the pipe boundary handshakes; words moving between
  // internal stages do not change the count. A simultaneous push and pop
  // leaves it unchanged, and flush clears it along with the stages.
  always_comb begin
    occCount_d = occCount_q;
    if (flush) begin
      occCount_d = '0;
    end else if (occPush && !occPop) begin
      occCount_d = occCount_q + OCC_W'(1);
    end else if (occPop && !occPush) begin
      occCount_d = occCount_q - OCC_W'(1);
    end
  end

  // Occupancy register, cleared asynchronously together with the stages.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      occCount_q <= '0;
    end else begin
      occCount_q <= occCount_d;
    end
  end

  assign occ = occCount_q;
`endif

endmodule

// File: tb/tb_reg_pipe_nb.sv
// ---------------------------------------------------------------------------
// tb_reg_pipe_nb
//   Self-checking bench for reg_pipe_nb (N=8, STAGES=2). Inputs change on the
//   falling edge and outputs are observed on the falling edge, away from the
//   active rising edge. Occupancy checks are compiled in with REG_PIPE_OCC_EN.
// ---------------------------------------------------------------------------
module tb_reg_pipe_nb;

  localparam int N      = 8;
  localparam int STAGES = 2;
  localparam int CAP    = 2 * STAGES;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         flush;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
`ifdef REG_PIPE_OCC_EN
  logic [$clog2(2*STAGES+1)-1:0] occ;
`endif

  int total = 0;
  int bad   = 0;

  reg_pipe_nb #(
    .N      (N),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef REG_PIPE_OCC_EN
    .occ       (occ),
`endif
    .out_ready (out_ready)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic       inValid;
    logic [7:0] inData;
    logic       outReady;
    logic       fl;
    logic       expOutValid;
    logic [7:0] expOutData;
    logic       expInReady;
    int         expOcc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] model[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] id,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One cycle of the randomized phase: check the DUT against the queue model,
  // drive new inputs, then update the queue with the handshakes that the
  // coming rising edge will perform.
  task automatic modelStep(input logic iv, input logic [7:0] id,
                           input logic ordy, input logic fl);
    logic willPush;
    logic willPop;
    if (model.size() == 0) begin
      checkOutput("rnd_valid_when_empty", 32'(out_valid), 32'd0);
    end else if (out_valid) begin
      checkOutput("rnd_order", 32'(out_data), 32'(model[0]));
    end
    if (model.size() == CAP) begin
      checkOutput("rnd_ready_when_full", 32'(in_ready), 32'd0);
    end
`ifdef REG_PIPE_OCC_EN
    checkOutput("rnd_occ", 32'(occ), 32'(model.size()));
`endif
    applyStimulus(iv, id, ordy, fl);
    willPush = iv & in_ready;
    willPop  = out_valid & ordy;
    if (fl) begin
      model.delete();
    end else begin
      if (willPop && model.size() > 0) begin
        void'(model.pop_front());
      end
      if (willPush) begin
        model.push_back(id);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         seen;
    logic       ivNext;
    logic [7:0] idNext;

    // ---------------- reset with a handshake attempt -----------------------
    clr_n = 1'b0;
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef REG_PIPE_OCC_EN
    checkOutput("rst_occ", 32'(occ), 32'd0);
`endif
    clr_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_nothing_accepted", 32'(out_valid), 32'd0);
    checkOutput("rst_release_ready", 32'(in_ready), 32'd1);

    // ---------------- streaming at full rate -------------------------------
    // A word driven in cycle s is expected at the output in cycle s+2.
    seen = 0;
    for (int s = 0; s < 20; s++) begin
      checkOutput("stream_valid", 32'(out_valid), 32'((s >= 2) && (s < 18)));
      if ((s >= 2) && (s < 18)) begin
        checkOutput("stream_data", 32'(out_data), 32'(s - 1));
      end
      if (out_valid) seen++;
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(s < 16, 8'(s + 1), 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("stream_valid_count", 32'(seen), 32'd16);

    // ---------------- table: backpressure then flush when full -------------
    // Fields: inValid inData outReady flush | expOutValid expOutData expInReady expOcc
    vecs.push_back(vec_t'{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1});
    vecs.push_back(vec_t'{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 2});
    vecs.push_back(vec_t'{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 3});
    vecs.push_back(vec_t'{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 4});
    vecs.push_back(vec_t'{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b0, 4});
    vecs.push_back(vec_t'{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 3});
    vecs.push_back(vec_t'{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 2});
    vecs.push_back(vec_t'{1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 2});
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b1, 1});
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0});
    vecs.push_back(vec_t'{1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1});
    vecs.push_back(vec_t'{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b1, 2});
    vecs.push_back(vec_t'{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b1, 3});
    vecs.push_back(vec_t'{1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 8'hB0, 1'b0, 4});
    vecs.push_back(vec_t'{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0});
    vecs.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].inValid, vecs[i].inData, vecs[i].outReady, vecs[i].fl);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].expOutValid));
      if (vecs[i].expOutValid) begin
        checkOutput($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(vecs[i].expOutData));
      end
      checkOutput($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expInReady));
`ifdef REG_PIPE_OCC_EN
      checkOutput($sformatf("tbl%0d_occ", i), 32'(occ), 32'(vecs[i].expOcc));
`endif
    end

    // ---------------- reset between clock edges with 3 words held ----------
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("mid_pre_data", 32'(out_data), 32'hC0);
    #2;
    clr_n = 1'b0;
    #1;
    checkOutput("mid_async_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_async_data", 32'(out_data), 32'h00);
    checkOutput("mid_async_ready", 32'(in_ready), 32'd1);
`ifdef REG_PIPE_OCC_EN
    checkOutput("mid_async_occ", 32'(occ), 32'd0);
`endif
    @(negedge clk);
    clr_n = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mid_fresh_valid0", 32'(out_valid), 32'd0);
    checkOutput("mid_fresh_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mid_fresh_valid1", 32'(out_valid), 32'd1);
    checkOutput("mid_fresh_data", 32'(out_data), 32'h77);
    @(negedge clk);
    checkOutput("mid_fresh_drained", 32'(out_valid), 32'd0);

    // ---------------- randomized traffic against the queue model -----------
    model.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (in_valid && !in_ready) begin
        ivNext = in_valid;
        idNext = in_data;
      end else begin
        ivNext = ($urandom_range(0, 99) < 60);
        idNext = 8'($urandom_range(0, 255));
      end
      modelStep(ivNext, idNext,
                $urandom_range(0, 99) < ((cyc < 250) ? 30 : 80),
                $urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    for (int cyc = 0; cyc < 12; cyc++) begin
      modelStep(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
